// File: rtl/mem_initiator.sv
// mem_initiator: datapath-side load/store initiator for a byte-addressed 16-bit memory.
// Accepts one request in IDLE and drives address, lane write enables and write data
// for the whole ACCESS phase. It returns the load data with a one-cycle done pulse.
// An access aborts with err if mem_r does not arrive within TIMEOUT_CYCLES.
// Optional feature macro: ALIGN_CHECK_EN. When it is defined, a misaligned word access
// is rejected with err and is never issued. When it is undefined, the address LSB of a
// word access is cleared instead.
// Handshake: a request transfers on a rising edge where req_valid_i & req_ready_o are both 1.
// req_ready is high only in IDLE. req_* inputs are ignored in every other state.
module mem_initiator #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we1,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_r,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    // Value of the cycle counter during the last ACCESS cycle before a timeout.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  mem_en_q, mem_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we1_q, we1_d;
    logic                  we0_q, we0_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  byte_q, byte_d;
    logic                  lsb_q, lsb_d;
    logic                  write_q, write_d;
    logic                  issue;

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            mem_en_q  <= 1'b0;
            addr_q    <= '0;
            we1_q     <= 1'b0;
            we0_q     <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= 8'd0;
            byte_q    <= 1'b0;
            lsb_q     <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            mem_en_q  <= mem_en_d;
            addr_q    <= addr_d;
            we1_q     <= we1_d;
            we0_q     <= we0_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            lsb_q     <= lsb_d;
            write_q   <= write_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for mem_r or the timeout, then pulse done.
    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_data_d = rd_data_q;
        mem_en_d  = mem_en_q;
        addr_d    = addr_q;
        we1_d     = we1_q;
        we0_d     = we0_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        lsb_d     = lsb_q;
        write_d   = write_q;
        issue     = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
`ifdef ALIGN_CHECK_EN
                    issue = req_byte | ~req_addr[0];
`endif
                    ready_d = 1'b0;
                    byte_d  = req_byte;
                    lsb_d   = req_addr[0];
                    write_d = req_write;
                    cnt_d   = 8'd0;
                    if (issue) begin
                        state_d  = S_ACCESS;
                        mem_en_d = 1'b1;
                        if (req_byte) begin
                            // A byte store replicates its data on both lanes.
                            // Only the lane that the address selects is enabled.
                            addr_d  = req_addr;
                            we1_d   = req_write & req_addr[0];
                            we0_d   = req_write & ~req_addr[0];
                            wdata_d = {req_wdata[7:0], req_wdata[7:0]};
                        end else begin
                            addr_d  = {req_addr[ADDR_WIDTH-1:1], 1'b0};
                            we1_d   = req_write;
                            we0_d   = req_write;
                            wdata_d = req_wdata;
                        end
                    end else begin
                        // A rejected misaligned word access goes straight to DONE.
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        mem_en_d = 1'b0;
                        we1_d    = 1'b0;
                        we0_d    = 1'b0;
                    end
                end
            end
            S_ACCESS: begin
                cnt_d = 8'(cnt_q + 8'd1);
                if (mem_r) begin
                    // mem_r has priority over a timeout that falls in the same cycle.
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    mem_en_d = 1'b0;
                    we1_d    = 1'b0;
                    we0_d    = 1'b0;
                    if (!write_q) begin
                        if (byte_q) begin
                            rd_data_d = {8'h00, (lsb_q ? mem_rdata[15:8] : mem_rdata[7:0])};
                        end else begin
                            rd_data_d = mem_rdata;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    mem_en_d = 1'b0;
                    we1_d    = 1'b0;
                    we0_d    = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = rd_data_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = addr_q;
    assign mem_we1   = we1_q;
    assign mem_we0   = we0_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed bench for mem_initiator, built with TIMEOUT_CYCLES = 4.
// Every expected value below is worked out by hand from the intended behaviour.
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_byte;
    logic [15:0] req_addr, req_wdata;
    logic        done, err;
    logic [15:0] rd_data;
    logic        mem_en, mem_we1, mem_we0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_r;
    logic [1:0]  dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    mem_initiator #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_byte (req_byte),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .done     (done),
        .err      (err),
        .rd_data  (rd_data),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_we1  (mem_we1),
        .mem_we0  (mem_we0),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_r    (mem_r),
        .dbg_state(dbg_state)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Advance one clock, settling 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request and check the whole ACCESS phase and the done phase.
    // nr is the ACCESS cycle (1-based) on which mem_r pulses; 0 means it never pulses.
    task automatic do_access(input string tag, input logic wr, input logic by,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input int nr, input logic [15:0] rdata,
                             input logic [15:0] e_addr, input logic e_we1, input logic e_we0,
                             input logic [15:0] e_wdata, input int e_cycles,
                             input logic e_err, input logic [15:0] e_rd);
        int   cycles;
        logic got;
        exp_q.push_back(e_rd);
        chk({tag, ".ready_idle"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = by;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = 16'hFFFF;
        cycles    = 0;
        got       = 1'b0;
        while (!got && cycles < 12) begin
            cycles++;
            chk({tag, ".mem_en"}, mem_en, 1'b1);
            chk({tag, ".mem_addr"}, mem_addr, e_addr);
            chk({tag, ".we1"}, mem_we1, e_we1);
            chk({tag, ".we0"}, mem_we0, e_we0);
            chk({tag, ".wdata"}, mem_wdata, e_wdata);
            chk({tag, ".ready_busy"}, req_ready, 1'b0);
            if (cycles == nr) begin
                mem_r     = 1'b1;
                mem_rdata = rdata;
            end
            tick();
            mem_r     = 1'b0;
            mem_rdata = 16'h0000;
            got       = done;
        end
        chk({tag, ".cycles"}, cycles, e_cycles);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".err"}, err, e_err);
        chk({tag, ".rd_data"}, rd_data, exp_q.pop_front());
        chk({tag, ".mem_en_off"}, mem_en, 1'b0);
        chk({tag, ".we_off"}, {mem_we1, mem_we0}, 2'b00);
        tick();
        chk({tag, ".done_clr"}, done, 1'b0);
        chk({tag, ".ready_back"}, req_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        mem_rdata = 16'h0000;
        mem_r     = 1'b0;
        tick();
        tick();
        chk("rst.ready", req_ready, 1'b1);
        chk("rst.done_err", {done, err}, 2'b00);
        chk("rst.mem_en_we", {mem_en, mem_we1, mem_we0}, 3'b000);
        chk("rst.addr_wdata_rd", {mem_addr, mem_wdata, rd_data}, 48'h0);
        chk("rst.state", dbg_state, 2'd0);
        rst = 1'b1;
        tick();

        // Word store; mem_r on the third ACCESS cycle, so done follows at cycle 4.
        do_access("wst", 1'b1, 1'b0, 16'h3000, 16'hBEEF, 3, 16'h0000,
                  16'h3000, 1'b1, 1'b1, 16'hBEEF, 3, 1'b0, 16'h0000);
        // Word load.
        do_access("wld", 1'b0, 1'b0, 16'h2002, 16'h0000, 1, 16'h1234,
                  16'h2002, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 16'h1234);
        // Byte loads: the high lane is selected for an odd address, the low lane for an even one.
        do_access("bld_hi", 1'b0, 1'b1, 16'h3001, 16'h0000, 1, 16'hA55A,
                  16'h3001, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 16'h00A5);
        do_access("bld_lo", 1'b0, 1'b1, 16'h3000, 16'h0000, 2, 16'hA55A,
                  16'h3000, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 16'h005A);
        // Byte stores: the low byte is replicated on both lanes and the address picks one enable.
        do_access("bst_hi", 1'b1, 1'b1, 16'h4001, 16'h12C3, 1, 16'h9999,
                  16'h4001, 1'b1, 1'b0, 16'hC3C3, 1, 1'b0, 16'h005A);
        do_access("bst_lo", 1'b1, 1'b1, 16'h4000, 16'h12C3, 2, 16'h9999,
                  16'h4000, 1'b0, 1'b1, 16'hC3C3, 2, 1'b0, 16'h005A);
        // Timeout: mem_en is high for 4 cycles, then done with err, and rd_data is kept.
        do_access("tmo", 1'b0, 1'b0, 16'h6000, 16'h0000, 0, 16'h0000,
                  16'h6000, 1'b0, 1'b0, 16'h0000, 4, 1'b1, 16'h005A);
        // mem_r on the limit cycle completes normally.
        do_access("tmo_edge", 1'b0, 1'b0, 16'h6002, 16'h0000, 4, 16'h7777,
                  16'h6002, 1'b0, 1'b0, 16'h0000, 4, 1'b0, 16'h7777);

        // Misaligned word load.
`ifdef ALIGN_CHECK_EN
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h5001;
        tick();
        req_valid = 1'b0;
        chk("mis.mem_en", mem_en, 1'b0);
        chk("mis.done_err", {done, err}, 2'b11);
        chk("mis.rd_data", rd_data, 16'h7777);
        tick();
        chk("mis.ready_back", {req_ready, done}, 2'b10);
`else
        do_access("mis", 1'b0, 1'b0, 16'h5001, 16'h0000, 2, 16'hCAFE,
                  16'h5000, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 16'hCAFE);
`endif

        // mem_r while IDLE is ignored.
        mem_r     = 1'b1;
        mem_rdata = 16'h1111;
        tick();
        mem_r = 1'b0;
        chk("idle_mem_r.done", {done, mem_en}, 2'b00);
        tick();
        chk("idle_mem_r.done2", done, 1'b0);

        // Reset in the middle of ACCESS abandons the access without a done pulse.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'h7000;
        req_wdata = 16'h5555;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid.mem_en", mem_en, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst.ready", req_ready, 1'b1);
        chk("mid_rst.en_we_done", {mem_en, mem_we1, mem_we0, done, err}, 5'b00000);
        chk("mid_rst.addr_wdata_rd", {mem_addr, mem_wdata, rd_data}, 48'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst.done", {done, mem_en}, 2'b00);
        chk("post_rst.ready", req_ready, 1'b1);
        chk("post_rst.state", dbg_state, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
